iot_teletype: RTL and testbench

Console teletype device on the IOT distributor bus, acting as the responder to CPU IOT instructions (KL8E-style keyboard device 03 and printer device 04). It decodes IOT strobes and returns AC-clear, read data and skip to the CPU. It buffers one keyboard byte from an external source and paces printer output through a busy delay and a valid/ready handshake. Its datain path feeds the CPU's OR-datain-into-AC operation, and it accepts the low 8 AC bits the CPU drives on dataout.

---
 rtl/iot_teletype.sv | 142 ++++++++++++++
 tb/tb_iot_teletype.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_teletype.sv
// Console teletype IOT responder: keyboard (device 03) and printer (device 04) with registered CPU response.
// Optional interrupt enable register and int_req generation when IOT_INTERRUPT_EN is defined.
module iot_teletype #(
  parameter logic [5:0]  KBD_DEV   = 6'o03,
  parameter logic [5:0]  PRT_DEV   = 6'o04,
  parameter int unsigned PRT_DELAY = 16
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       iot_valid,
  input  logic [5:0] iot_dev,
  input  logic [2:0] iot_op,
  input  logic [7:0] dataout,
  output logic [7:0] datain,
  output logic       ac_clear,
  output logic       iot_skip,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       prt_valid,
  output logic [7:0] prt_data,
  input  logic       prt_ready,
  output logic       int_req
);

  localparam int unsigned CW = $clog2(PRT_DELAY + 1);

  typedef enum logic [1:0] {P_IDLE, P_BUSY, P_OUT} prt_state_t;

  prt_state_t    state, state_next;
  logic [CW-1:0] cnt;
  logic          kbd_flag, prt_flag;
  logic [7:0]    kbd_buf, prt_buf;
  logic          kbd_sel, prt_sel, kie, kbd_cmd;
  logic          kbd_accept, prt_done, tpc_start;

  assign kbd_sel = iot_valid && (iot_dev == KBD_DEV);
  assign prt_sel = iot_valid && (iot_dev == PRT_DEV);

`ifdef IOT_INTERRUPT_EN
  assign kie = kbd_sel && (iot_op == 3'd5);
`else
  assign kie = 1'b0;
`endif

  // KIE replaces the KSF/KRS meaning of op 5 when interrupts are built in
  assign kbd_cmd    = kbd_sel && !kie;
  assign kbd_ready  = !kbd_flag;
  assign kbd_accept = kbd_valid && !kbd_flag;
  assign prt_done   = (state == P_OUT) && prt_ready;
  assign tpc_start  = prt_sel && iot_op[2] && (state == P_IDLE);

  always_ff @(posedge clock) begin
    if (!resetN) begin
      kbd_flag <= 1'b0;
      kbd_buf  <= '0;
    end else if (kbd_accept) begin
      kbd_flag <= 1'b1;
      kbd_buf  <= kbd_data;
    end else if (kbd_cmd && iot_op[1]) begin
      kbd_flag <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      prt_flag <= 1'b0;
      prt_buf  <= '0;
    end else begin
      if (prt_done)
        prt_flag <= 1'b1;
      else if (prt_sel && iot_op[1])
        prt_flag <= 1'b0;
      if (tpc_start)
        prt_buf <= dataout;
    end
  end

  // Skip and read data reflect flag/buffer contents before this cycle's updates
  always_ff @(posedge clock) begin
    if (!resetN) begin
      datain   <= '0;
      ac_clear <= 1'b0;
      iot_skip <= 1'b0;
    end else begin
      datain   <= (kbd_cmd && iot_op[2]) ? kbd_buf : '0;
      ac_clear <= kbd_cmd && iot_op[1];
      iot_skip <= (kbd_cmd && iot_op[0] && kbd_flag) ||
                  (prt_sel && iot_op[0] && prt_flag);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state <= P_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (tpc_start)
        cnt <= CW'(PRT_DELAY - 1);
      else if ((state == P_BUSY) && (cnt != '0))
        cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      P_IDLE: if (tpc_start) state_next = P_BUSY;
      P_BUSY: if (cnt == '0) state_next = P_OUT;
      P_OUT:  if (prt_ready) state_next = P_IDLE;
      default: state_next = P_IDLE;
    endcase
  end

  always_comb begin
    prt_valid = 1'b0;
    prt_data  = '0;
    if (state == P_OUT) begin
      prt_valid = 1'b1;
      prt_data  = prt_buf;
    end
  end

`ifdef IOT_INTERRUPT_EN
  logic int_en;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      int_en  <= 1'b0;
      int_req <= 1'b0;
    end else begin
      if (kie)
        int_en <= dataout[0];
      int_req <= int_en && (kbd_flag || prt_flag);
    end
  end
`else
  assign int_req = 1'b0;
`endif

endmodule

// File: tb/tb_iot_teletype.sv
// Bench for iot_teletype: directed scenarios plus randomized traffic against a cycle-count reference model.
// Build with IOT_INTERRUPT_EN defined to exercise the interrupt variant.
module tb_iot_teletype;
  localparam int unsigned D = 16;

  logic       clock = 1'b0, resetN = 1'b0, iot_valid = 1'b0;
  logic [5:0] iot_dev = '0;
  logic [2:0] iot_op = '0;
  logic [7:0] dataout = '0, kbd_data = '0;
  logic       kbd_valid = 1'b0, prt_ready = 1'b0;
  logic [7:0] datain, prt_data;
  logic       ac_clear, iot_skip, kbd_ready, prt_valid, int_req;

  int n_cmp = 0, n_bad = 0;

  // reference model: printer tracked as "printing since cycle X, output from cycle Y"
  int         cyc = 0, m_print_at = 0;
  logic       m_kflag = 0, m_pflag = 0, m_printing = 0, m_inten = 0;
  logic [7:0] m_kbuf = '0, m_pbyte = '0;
  logic [7:0] e_datain = '0, e_pdata = '0;
  logic       e_clr = 0, e_skip = 0, e_pvalid = 0, e_kready = 1, e_int = 0;

  iot_teletype #(.KBD_DEV(6'o03), .PRT_DEV(6'o04), .PRT_DELAY(D)) dut (
    .clock(clock), .resetN(resetN), .iot_valid(iot_valid), .iot_dev(iot_dev),
    .iot_op(iot_op), .dataout(dataout), .datain(datain), .ac_clear(ac_clear),
    .iot_skip(iot_skip), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
    .kbd_ready(kbd_ready), .prt_valid(prt_valid), .prt_data(prt_data),
    .prt_ready(prt_ready), .int_req(int_req)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    logic ks, ps, kie, pv, acc, done, start;
    ks  = iot_valid && (iot_dev == 6'o03);
    ps  = iot_valid && (iot_dev == 6'o04);
    kie = 1'b0;
`ifdef IOT_INTERRUPT_EN
    kie = ks && (iot_op == 3'd5);
`endif
    pv    = m_printing && (cyc >= m_print_at);
    acc   = kbd_valid && !m_kflag;
    done  = pv && prt_ready;
    start = ps && iot_op[2] && !m_printing;
    e_int = m_inten && (m_kflag || m_pflag);
    e_datain = (ks && !kie && iot_op[2]) ? m_kbuf : 8'h00;
    e_clr    = ks && !kie && iot_op[1];
    e_skip   = (ks && !kie && iot_op[0] && m_kflag) || (ps && iot_op[0] && m_pflag);
    if (ks && !kie && iot_op[1]) m_kflag = 1'b0;
    if (acc) begin m_kflag = 1'b1; m_kbuf = kbd_data; end
    if (ps && iot_op[1]) m_pflag = 1'b0;
    if (done) begin m_pflag = 1'b1; m_printing = 1'b0; end
    if (start) begin m_printing = 1'b1; m_pbyte = dataout; m_print_at = cyc + 1 + D; end
    if (kie) m_inten = dataout[0];
    if (!resetN) begin
      m_kflag = 0; m_pflag = 0; m_printing = 0; m_inten = 0; m_kbuf = '0; m_pbyte = '0;
      e_datain = '0; e_clr = 0; e_skip = 0; e_int = 0;
    end
    cyc++;
    e_pvalid = m_printing && (cyc >= m_print_at);
    e_pdata  = e_pvalid ? m_pbyte : 8'h00;
    e_kready = !m_kflag;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic iot(input logic [5:0] dev, input logic [2:0] op, input logic [7:0] d);
    iot_valid = 1'b1; iot_dev = dev; iot_op = op; dataout = d;
    tick();
    iot_valid = 1'b0; iot_op = '0; dataout = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!prt_valid && n < 64) begin tick(); n++; end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({datain, ac_clear, iot_skip, prt_valid, prt_data, kbd_ready, int_req} !== {8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got datain=%h clr=%b skip=%b pv=%b pd=%h kr=%b int=%b, expected all 0 with kbd_ready=1",
               datain, ac_clear, iot_skip, prt_valid, prt_data, kbd_ready, int_req);
    end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_keyboard();
    kbd_data = 8'h41; kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    n_cmp++;
    if (kbd_ready !== 1'b0) begin n_bad++; $display("FAIL kbd_ready_after_accept: got %b expected 0", kbd_ready); end
    iot(6'o03, 3'd1, 8'h00);
    n_cmp++;
    if (iot_skip !== 1'b1) begin n_bad++; $display("FAIL ksf_skip: got %b expected 1", iot_skip); end
    tick();
    n_cmp++;
    if (iot_skip !== 1'b0) begin n_bad++; $display("FAIL skip_one_cycle: got %b expected 0", iot_skip); end
    iot(6'o03, 3'd6, 8'h00);
    n_cmp++;
    if ({ac_clear, datain} !== {1'b1, 8'h41}) begin
      n_bad++; $display("FAIL krb_read: got clr=%b datain=%h expected clr=1 datain=41", ac_clear, datain);
    end
    tick();
    n_cmp++;
    if ({kbd_ready, ac_clear, datain} !== {1'b1, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL krb_after: got kr=%b clr=%b datain=%h expected 1 0 00", kbd_ready, ac_clear, datain);
    end
  endtask

  task automatic test_printer();
    int n;
    iot(6'o04, 3'd6, 8'h5A);
    wait_valid(n);
    n_cmp++;
    if (n != D) begin n_bad++; $display("FAIL prt_latency: got %0d cycles expected %0d", n, D); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({prt_valid, prt_data} !== {1'b1, 8'h5A}) begin
        n_bad++; $display("FAIL prt_hold[%0d]: got pv=%b pd=%h expected 1 5a", i, prt_valid, prt_data);
      end
      tick();
    end
    prt_ready = 1'b1;
    tick();
    prt_ready = 1'b0;
    n_cmp++;
    if (prt_valid !== 1'b0) begin n_bad++; $display("FAIL prt_drop: got %b expected 0", prt_valid); end
    iot(6'o04, 3'd1, 8'h00);
    n_cmp++;
    if (iot_skip !== 1'b1) begin n_bad++; $display("FAIL tsf_skip: got %b expected 1", iot_skip); end
    iot(6'o04, 3'd2, 8'h00);
  endtask

  task automatic test_no_overwrite();
    kbd_data = 8'h41; kbd_valid = 1'b1;
    tick();
    kbd_data = 8'h42;
    tick(); tick(); tick();
    n_cmp++;
    if (kbd_ready !== 1'b0) begin n_bad++; $display("FAIL kbd_ready_full: got %b expected 0", kbd_ready); end
    iot(6'o03, 3'd4, 8'h00);
    n_cmp++;
    if (datain !== 8'h41) begin n_bad++; $display("FAIL kbd_no_overwrite: got %h expected 41", datain); end
    iot(6'o03, 3'd2, 8'h00);
    tick();
    kbd_valid = 1'b0;
    iot(6'o03, 3'd4, 8'h00);
    n_cmp++;
    if (datain !== 8'h42) begin n_bad++; $display("FAIL kbd_second_byte: got %h expected 42", datain); end
    iot(6'o03, 3'd2, 8'h00);
  endtask

  task automatic test_ignore();
    int n;
    iot(6'o04, 3'd4, 8'h77);
    tick(); tick(); tick();
    iot(6'o04, 3'd4, 8'h33);
    iot(6'o05, 3'd7, 8'hFF);
    n_cmp++;
    if ({datain, ac_clear, iot_skip} !== 10'h000) begin
      n_bad++; $display("FAIL other_dev: got datain=%h clr=%b skip=%b expected 00 0 0", datain, ac_clear, iot_skip);
    end
    wait_valid(n);
    n_cmp++;
    if (n != D - 5) begin n_bad++; $display("FAIL busy_no_restart: got %0d cycles expected %0d", n, D - 5); end
    n_cmp++;
    if (prt_data !== 8'h77) begin n_bad++; $display("FAIL busy_tpc_ignored: got %h expected 77", prt_data); end
    prt_ready = 1'b1;
    tick();
    prt_ready = 1'b0;
    iot(6'o04, 3'd2, 8'h00);
  endtask

  task automatic test_reset_in_out();
    int n;
    iot(6'o04, 3'd4, 8'hA5);
    kbd_data = 8'h99; kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    wait_valid(n);
    resetN = 1'b0;
    tick();
    n_cmp++;
    if ({prt_valid, kbd_ready} !== 2'b01) begin
      n_bad++; $display("FAIL reset_in_out: got pv=%b kr=%b expected 0 1", prt_valid, kbd_ready);
    end
    resetN = 1'b1;
    iot(6'o04, 3'd1, 8'h00);
    n_cmp++;
    if (iot_skip !== 1'b0) begin n_bad++; $display("FAIL reset_no_flag: got skip=%b expected 0", iot_skip); end
    tick(); tick();
    n_cmp++;
    if (prt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_aborts: got pv=%b expected 0", prt_valid); end
  endtask

  task automatic test_op5();
`ifdef IOT_INTERRUPT_EN
    iot(6'o03, 3'd5, 8'h01);
    kbd_data = 8'h55; kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    tick();
    n_cmp++;
    if (int_req !== 1'b1) begin n_bad++; $display("FAIL int_req_set: got %b expected 1", int_req); end
    iot(6'o03, 3'd2, 8'h00);
    tick();
    n_cmp++;
    if (int_req !== 1'b0) begin n_bad++; $display("FAIL int_req_clear: got %b expected 0", int_req); end
    iot(6'o03, 3'd5, 8'h00);
`else
    kbd_data = 8'h55; kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    iot(6'o03, 3'd5, 8'h01);
    n_cmp++;
    if ({iot_skip, ac_clear, datain, int_req} !== {1'b1, 1'b0, 8'h55, 1'b0}) begin
      n_bad++; $display("FAIL op5_ksf_krs: got skip=%b clr=%b datain=%h int=%b expected 1 0 55 0",
                        iot_skip, ac_clear, datain, int_req);
    end
    iot(6'o03, 3'd2, 8'h00);
`endif
  endtask

  task automatic test_random();
    logic [20:0] got, exp;
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      iot_valid = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 3))
        0: iot_dev = 6'o03;
        1: iot_dev = 6'o04;
        2: iot_dev = 6'o05;
        default: iot_dev = 6'($urandom);
      endcase
      iot_op    = 3'($urandom);
      dataout   = 8'($urandom);
      kbd_valid = ($urandom_range(0, 9) < 3);
      kbd_data  = 8'($urandom);
      prt_ready = $urandom_range(0, 1) == 1;
      resetN    = ($urandom_range(0, 299) != 0);
      tick();
      got = {datain, ac_clear, iot_skip, prt_valid, prt_data, kbd_ready, int_req};
      exp = {e_datain, e_clr, e_skip, e_pvalid, e_pdata, e_kready, e_int};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
      end
    end
    iot_valid = 1'b0; kbd_valid = 1'b0; prt_ready = 1'b0; resetN = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_keyboard();
    test_printer();
    test_no_overwrite();
    test_ignore();
    test_reset_in_out();
    test_op5();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
